// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: receive side of the multiplexed FND display bus.
// Watches the active-low segment bus and digit-common lines and recovers the
// hex nibble shown on each digit after it has been stable for STABLE_CYCLES
// synchronized samples.
// Optional feature: define FND_DP_CAPTURE_EN to latch the decimal point of
// every captured digit on o_dp. Without it o_dp is tied to 0.
module fnd_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [7:0]            i_fndSeg,
   input  logic [DIGITS-1:0]     i_fndCom,
   output logic [4*DIGITS-1:0]   o_digits,
   output logic [DIGITS-1:0]     o_dp,
   output logic [DIGITS-1:0]     o_digitValid,
   output logic                  o_invalid,
   output logic                  o_frameDone
);

   localparam int         BUS_W   = 8 + DIGITS;
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
`ifdef FND_DP_CAPTURE_EN
   localparam int         CAP_SEG_W = 8;
`else
   localparam int         CAP_SEG_W = 7;
`endif
   localparam int         CAP_W   = CAP_SEG_W + DIGITS;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_e;

   logic [BUS_W-1:0]    s1_q, s1_d, s2_q, s2_d, p_q, p_d;
   logic [CAP_W-1:0]    cap_q, cap_d;
   logic [7:0]          cnt_q, cnt_d;
   state_e              state_q, state_d;
   logic [DIGITS-1:0]   mask_q, mask_d, valid_q, valid_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic                invalid_q, invalid_d, frame_done_q, frame_done_d;
`ifdef FND_DP_CAPTURE_EN
   logic [DIGITS-1:0]   dp_q, dp_d;
`endif

   logic [DIGITS-1:0]    s2_com, cap_com, cap_hit_mask;
   logic [CAP_SEG_W-1:0] cap_seg;
   logic                 changed, s2_one_low, glyph_hit, glyph_blank;
   logic [3:0]           glyph_val;

   // True when exactly one digit-common line is driven low.
   function automatic logic one_low(input logic [DIGITS-1:0] com);
      int lows;
      lows = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!com[i]) lows++;
      end
      return (lows == 1);
   endfunction

   assign s2_com     = s2_q[DIGITS-1:0];
   assign cap_com    = cap_q[DIGITS-1:0];
   assign cap_seg    = cap_q[CAP_W-1:DIGITS];
   assign changed    = (s2_q != p_q);
   assign s2_one_low = one_low(s2_com);

   // Invert the active-low hex glyph table; dp is ignored for the match.
   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      glyph_hit   = 1'b1;
      glyph_val   = 4'h0;
      glyph_blank = (cap_seg[6:0] == 7'h7f);
      case ({1'b1, cap_seg[6:0]})
         8'hc0:   glyph_val = 4'h0;
         8'hf9:   glyph_val = 4'h1;
         8'ha4:   glyph_val = 4'h2;
         8'hb0:   glyph_val = 4'h3;
         8'h99:   glyph_val = 4'h4;
         8'h92:   glyph_val = 4'h5;
         8'h82:   glyph_val = 4'h6;
         8'hf8:   glyph_val = 4'h7;
         8'h80:   glyph_val = 4'h8;
         8'h90:   glyph_val = 4'h9;
         8'h88:   glyph_val = 4'ha;
         8'h83:   glyph_val = 4'hb;
         8'hc6:   glyph_val = 4'hc;
         8'ha1:   glyph_val = 4'hd;
         8'h86:   glyph_val = 4'he;
         8'h8e:   glyph_val = 4'hf;
         default: glyph_hit = 1'b0;
      endcase
   end

   // Synchronizer, stability counter, scan FSM and capture/frame bookkeeping.
   always_comb begin
      s1_d         = {i_fndSeg, i_fndCom};
      s2_d         = s1_q;
      p_d          = s2_q;
      cap_d        = cap_q;
      state_d      = state_q;
      digits_d     = digits_q;
      valid_d      = valid_q;
      invalid_d    = 1'b0;
      cap_hit_mask = '0;
`ifdef FND_DP_CAPTURE_EN
      dp_d         = dp_q;
`endif

      if (changed)                cnt_d = '0;
      else if (cnt_q >= CNT_MAX)  cnt_d = CNT_MAX;
      else                        cnt_d = cnt_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            if (s2_one_low) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            // Zero or several lows is blanking/ghosting: abandon quietly.
            if (!s2_one_low) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_CAPTURE;
               // p is the newest sample the counter has already vouched for.
               cap_d   = {p_q[DIGITS +: CAP_SEG_W], p_q[DIGITS-1:0]};
            end
         end
         ST_CAPTURE: state_d = ST_HOLD;
         ST_HOLD: begin
            if (changed) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_CAPTURE) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (!cap_com[k]) begin
               cap_hit_mask[k] = 1'b1;
               valid_d[k]      = glyph_hit;
               if (glyph_hit) digits_d[4*k +: 4] = glyph_val;
`ifdef FND_DP_CAPTURE_EN
               dp_d[k]         = ~cap_seg[7];
`endif
            end
         end
         invalid_d = !glyph_hit && !glyph_blank;
      end

      // A capture landing on the clearing cycle seeds the next frame.
      frame_done_d = &mask_q;
      mask_d       = (frame_done_d ? '0 : mask_q) | cap_hit_mask;
   end

   // State registers; reset clears everything, including a pending capture.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_q         <= '0;
         s2_q         <= '0;
         p_q          <= '0;
         cap_q        <= '0;
         cnt_q        <= '0;
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         valid_q      <= '0;
         digits_q     <= '0;
         invalid_q    <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef FND_DP_CAPTURE_EN
         dp_q         <= '0;
`endif
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         p_q          <= p_d;
         cap_q        <= cap_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         mask_q       <= mask_d;
         valid_q      <= valid_d;
         digits_q     <= digits_d;
         invalid_q    <= invalid_d;
         frame_done_q <= frame_done_d;
`ifdef FND_DP_CAPTURE_EN
         dp_q         <= dp_d;
`endif
      end
   end

   assign o_digits     = digits_q;
   assign o_digitValid = valid_q;
   assign o_invalid    = invalid_q;
   assign o_frameDone  = frame_done_q;
`ifdef FND_DP_CAPTURE_EN
   assign o_dp         = dp_q;
`else
   assign o_dp         = '0;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb_fnd_scan_decoder: directed scenarios plus randomized scan traffic,
// every cycle compared against a run-length reference model.
`timescale 1ns/1ps
module tb_fnd_scan_decoder;

   localparam int D  = 4;
   localparam int S  = 16;
   localparam int BW = 8 + D;
`ifdef FND_DP_CAPTURE_EN
   localparam logic DP_ON = 1'b1;
`else
   localparam logic DP_ON = 1'b0;
`endif

   logic           clk   = 1'b0;
   logic           rst_n = 1'b1;
   logic [7:0]     seg   = 8'hff;
   logic [D-1:0]   com   = '1;
   logic [4*D-1:0] o_digits;
   logic [D-1:0]   o_dp, o_digitValid;
   logic           o_invalid, o_frameDone;

   always #5 clk = ~clk;

   fnd_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_fndSeg     (seg),
      .i_fndCom     (com),
      .o_digits     (o_digits),
      .o_dp         (o_dp),
      .o_digitValid (o_digitValid),
      .o_invalid    (o_invalid),
      .o_frameDone  (o_frameDone)
   );

   logic [7:0] glyph [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A digit is captured when its pattern has been sampled S times in a row
   // with exactly one common line low; the outputs change 4 edges after the
   // S-th sample (S+3 edges after the first one).
   typedef struct { int t; logic [7:0] s; logic [D-1:0] c; } cap_t;
   cap_t           pend[$];
   int             cyc     = 0;
   int             run_len = 0;
   logic [BW-1:0]  prev_x  = '0;
   logic [4*D-1:0] e_digits = '0;
   logic [D-1:0]   e_valid = '0, e_dp = '0, e_mask = '0;
   logic           e_inv = 1'b0, e_fd = 1'b0;

   function automatic bit one_low_m(input logic [D-1:0] c);
      return $countones(~c) == 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [BW-1:0] x;
      cap_t          cp;
      bit            hit;
      logic [3:0]    val;
      if (!rst_n) begin
         pend.delete();
         run_len  = 0;
         prev_x   = '0;
         e_digits = '0;
         e_valid  = '0;
         e_dp     = '0;
         e_mask   = '0;
         e_inv    = 1'b0;
         e_fd     = 1'b0;
      end else begin
         cyc++;
         x = {seg, com};
         if (x == prev_x) run_len++;
         else             run_len = 1;
         prev_x = x;
         if (run_len == S && one_low_m(com)) pend.push_back('{cyc + 4, seg, com});
         e_fd  = (e_mask == '1);
         if (e_fd) e_mask = '0;
         e_inv = 1'b0;
         if (pend.size() > 0 && pend[0].t == cyc) begin
            cp  = pend.pop_front();
            hit = 1'b0;
            val = 4'h0;
            for (int v = 0; v < 16; v++) begin
               if (glyph[v][6:0] == cp.s[6:0]) begin
                  hit = 1'b1;
                  val = 4'(v);
               end
            end
            for (int k = 0; k < D; k++) begin
               if (!cp.c[k]) begin
                  e_mask[k]  = 1'b1;
                  e_valid[k] = hit;
                  if (hit) e_digits[4*k +: 4] = val;
                  if (DP_ON) e_dp[k] = ~cp.s[7];
               end
            end
            e_inv = !hit && (cp.s[6:0] != 7'h7f);
         end
      end
   end

   // Cycle-by-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      check("digits", 64'(o_digits), 64'(e_digits));
      check("valid",  64'(o_digitValid), 64'(e_valid));
      check("dp",     64'(o_dp), 64'(e_dp));
      check("invalid", 64'(o_invalid), 64'(e_inv));
      check("frame_done", 64'(o_frameDone), 64'(e_fd));
   end

   // ---------------- stimulus ----------------
   int inv_cnt = 0;
   int fd_cnt  = 0;
   int lat     = -1;

   // Drive one pattern (called just after a falling edge) for n cycles,
   // counting pulses and noting the cycle the decoded outputs first move.
   task automatic hold(input logic [7:0] s, input logic [D-1:0] c, input int n);
      logic [4*D-1:0] d0;
      logic [D-1:0]   v0;
      seg = s;
      com = c;
      d0  = o_digits;
      v0  = o_digitValid;
      lat = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (o_invalid)   inv_cnt++;
         if (o_frameDone) fd_cnt++;
         if (lat < 0 && (o_digits != d0 || o_digitValid != v0)) lat = i;
      end
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int i0, f0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_digits", 64'(o_digits), 64'h0);
      check("rst_valid",  64'(o_digitValid), 64'h0);
      check("rst_pulses", 64'({o_invalid, o_frameDone, o_dp}), 64'h0);
      #2 rst_n = 1'b1;

      // Idle: nothing selected.
      hold(8'hff, 4'b1111, 100);
      check("idle_invalid", 64'(inv_cnt), 64'd0);
      check("idle_frame",   64'(fd_cnt), 64'd0);

      // Scan 1,2,3,4 across digits 0..3.
      hold(8'hf9, 4'b1110, 40);
      check("scan_latency", 64'(lat), 64'(S + 4));
      hold(8'ha4, 4'b1101, 40);
      hold(8'hb0, 4'b1011, 40);
      hold(8'h99, 4'b0111, 40);
      check("scan_digits", 64'(o_digits), 64'h4321);
      check("scan_valid",  64'(o_digitValid), 64'hf);
      check("scan_frame",  64'(fd_cnt), 64'd1);

      // Full glyph table on digit 0, with and without the decimal point.
      for (int v = 0; v < 16; v++) begin
         hold(glyph[v], 4'b1110, 40);
         check("table_nibble", 64'(o_digits[3:0]), 64'(v));
         check("table_valid",  64'(o_digitValid[0]), 64'd1);
      end
      for (int v = 0; v < 16; v++) begin
         hold(glyph[v] & 8'h7f, 4'b1110, 40);
         check("table_dp_nibble", 64'(o_digits[3:0]), 64'(v));
         check("table_dp", 64'(o_dp[0]), 64'(DP_ON));
      end

      // Illegal pattern, then blank, on digit 2.
      i0 = inv_cnt;
      hold(8'haa, 4'b1011, 40);
      check("illegal_pulse", 64'(inv_cnt - i0), 64'd1);
      check("illegal_valid", 64'(o_digitValid[2]), 64'd0);
      check("illegal_hold",  64'(o_digits[11:8]), 64'h3);
      hold(8'hff, 4'b1011, 40);
      check("blank_pulse", 64'(inv_cnt - i0), 64'd1);
      check("blank_valid", 64'(o_digitValid[2]), 64'd0);

      // Glitching segments on digit 3, then ghosting across digits 0 and 1.
      i0 = inv_cnt;
      f0 = fd_cnt;
      for (int g = 0; g < 12; g++) hold(g[0] ? 8'ha4 : 8'hf9, 4'b0111, 5);
      check("glitch_digit", 64'(o_digits[15:12]), 64'h4);
      hold(8'h80, 4'b1100, 50);
      check("ghost_digits",  64'(o_digits), 64'h432f);
      check("ghost_valid",   64'(o_digitValid), 64'hb);
      check("ghost_invalid", 64'(inv_cnt - i0), 64'd0);
      check("ghost_frame",   64'(fd_cnt - f0), 64'd0);

      // Reset part-way through settling on digit 1.
      hold(8'h92, 4'b1101, 10);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_digits", 64'(o_digits), 64'h0);
      check("midrst_valid",  64'(o_digitValid), 64'h0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (lat < 0 && o_digitValid[1]) lat = i;
      end
      check("midrst_latency", 64'(lat), 64'(S + 4));
      check("midrst_result",  64'(o_digits), 64'h0050);

      // Randomized traffic; run lengths avoid S and S+1 and every new
      // pattern differs from the previous one.
      for (int r = 0; r < 150; r++) begin
         logic [7:0]   s;
         logic [D-1:0] c;
         int           len, sel, a, b;
         do begin
            sel = int'($urandom_range(0, 9));
            c   = '1;
            if (sel < 7) begin
               c[$urandom_range(0, D-1)] = 1'b0;
            end else if (sel == 8) begin
               a    = int'($urandom_range(0, D-1));
               b    = (a + 1 + int'($urandom_range(0, D-2))) % D;
               c[a] = 1'b0;
               c[b] = 1'b0;
            end
            sel = int'($urandom_range(0, 7));
            if (sel < 5) begin
               s = glyph[$urandom_range(0, 15)];
               if ($urandom_range(0, 1) == 1) s[7] = 1'b0;
            end else if (sel == 5) begin
               s = 8'hff;
            end else begin
               s = 8'($urandom);
            end
         end while ({s, c} == {seg, com});
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S-2))
                                           : int'($urandom_range(S+2, S+30));
         hold(s, c, len);
      end
      hold(seg, com, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
